seq_shifter: RTL and testbench



---
 rtl/seq_shifter.sv | 132 +++++++++++++
 tb/tb_seq_shifter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: shifts a captured operand by up to STEP
// positions per clock and reports a registered result, carry and done pulse.
module seq_shifter #(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0]     MODE_SHL = 2'b00;
    localparam logic [1:0]     MODE_SHR = 2'b01;
    localparam logic [1:0]     MODE_SAR = 2'b10;
    localparam logic [SHW-1:0] STEP_W   = SHW'(STEP);

    state_t           state_reg;
    logic [WIDTH-1:0] work_reg;
    logic [SHW-1:0]   remaining_reg;
    logic [1:0]       mode_reg;
    logic             sign_reg;
    logic             carry_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [SHW-1:0]   step_k;
    logic [SHW-1:0]   hi_idx;
    logic [SHW-1:0]   lo_idx;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] step_next;
    logic             carry_next;

    // One step of k = min(STEP, remaining) positions on the working register.
    always_comb begin
        step_k     = (remaining_reg > STEP_W) ? STEP_W : remaining_reg;
        hi_idx     = SHW'(WIDTH - int'(step_k));
        lo_idx     = step_k - SHW'(1);
        fill_mask  = ~({WIDTH{1'b1}} >> step_k);
        step_next  = work_reg;
        carry_next = carry_reg;
        case (mode_reg)
            MODE_SHL: begin
                step_next  = work_reg << step_k;
                carry_next = work_reg[hi_idx];
            end
            MODE_SHR: begin
                step_next  = work_reg >> step_k;
                carry_next = work_reg[lo_idx];
            end
            MODE_SAR: begin
                step_next  = (work_reg >> step_k) | (sign_reg ? fill_mask : '0);
                carry_next = work_reg[lo_idx];
            end
            default: begin
                // Rotate: the bit landing in LSB is the one that left the MSB.
                step_next  = (work_reg << step_k) | (work_reg >> hi_idx);
                carry_next = work_reg[hi_idx];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            remaining_reg <= '0;
            mode_reg      <= MODE_SHL;
            sign_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        work_reg      <= a;
                        mode_reg      <= mode;
                        sign_reg      <= a[WIDTH-1];
                        carry_reg     <= 1'b0;
                        remaining_reg <= amt;
                        busy_reg      <= 1'b1;
                        if (amt != '0) begin
                            state_reg <= SHIFT;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work_reg      <= step_next;
                    carry_reg     <= carry_next;
                    remaining_reg <= remaining_reg - step_k;
                    if (remaining_reg <= STEP_W) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign result = work_reg;
    assign carry  = carry_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one STEP=1 and one STEP=4 instance, WIDTH=8.
module tb_seq_shifter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] a = '0;
    logic [2:0] amt = '0;
    logic [1:0] mode = '0;

    logic [7:0] result1, result4;
    logic       carry1, carry4, busy1, busy4, done1, done4;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(8), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .amt(amt), .mode(mode),
        .result(result1), .carry(carry1), .busy(busy1), .done(done1)
    );

    seq_shifter #(.WIDTH(8), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .amt(amt), .mode(mode),
        .result(result4), .carry(carry4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the chosen instance and check latency, result, carry, busy drop.
    task automatic run_op(input bit sel4, input logic [7:0] av, input logic [2:0] amtv,
                          input logic [1:0] mv, input logic [7:0] er, input logic ec,
                          input int lat, input string tag);
        int cyc;
        a = av; amt = amtv; mode = mv;
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0; start4 = 1'b0;
        a = ~av; amt = ~amtv; mode = ~mv;
        cyc = 1;
        while (!(sel4 ? done4 : done1) && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " result"}, sel4 ? result4 : result1, er);
        check({tag, " carry"}, sel4 ? carry4 : carry1, ec);
        check({tag, " busy in done"}, sel4 ? busy4 : busy1, 1);
        tick();
        check({tag, " busy after"}, sel4 ? busy4 : busy1, 0);
        check({tag, " done after"}, sel4 ? done4 : done1, 0);
        check({tag, " result held"}, sel4 ? result4 : result1, er);
        $display("op %s: a=%02h amt=%0d mode=%0d -> result=%02h carry=%0b lat=%0d",
                 tag, av, amtv, mv, sel4 ? result4 : result1, sel4 ? carry4 : carry1, cyc);
    endtask

    initial begin
        int cyc;
        int ndone;

        // Reset held two cycles with start asserted.
        #1;
        start1 = 1'b1; start4 = 1'b1; a = 8'h5A; amt = 3'd3;
        tick();
        tick();
        check("reset result", result1, 0);
        check("reset carry", carry1, 0);
        check("reset busy", busy1, 0);
        check("reset done", done1, 0);
        check("reset busy4", busy4, 0);
        start1 = 1'b0; start4 = 1'b0;
        rst_n = 1'b1;
        tick();
        check("idle after reset", busy1, 0);

        run_op(1'b0, 8'h96, 3'd3, 2'b00, 8'hB0, 1'b0, 4, "shl1");
        run_op(1'b0, 8'h96, 3'd2, 2'b01, 8'h25, 1'b1, 3, "shr1");
        run_op(1'b0, 8'h96, 3'd2, 2'b10, 8'hE5, 1'b1, 3, "sar1");
        run_op(1'b0, 8'h96, 3'd4, 2'b11, 8'h69, 1'b1, 5, "rol1");
        run_op(1'b0, 8'h5A, 3'd0, 2'b01, 8'h5A, 1'b0, 1, "amt0_1");
        run_op(1'b1, 8'h5A, 3'd0, 2'b11, 8'h5A, 1'b0, 1, "amt0_4");
        run_op(1'b1, 8'hFF, 3'd7, 2'b00, 8'h80, 1'b1, 3, "shl4");
        run_op(1'b0, 8'hFF, 3'd7, 2'b00, 8'h80, 1'b1, 8, "shl1_7");
        run_op(1'b1, 8'h81, 3'd7, 2'b01, 8'h01, 1'b0, 3, "shr4");
        run_op(1'b1, 8'h81, 3'd7, 2'b10, 8'hFF, 1'b0, 3, "sar4");
        run_op(1'b1, 8'h81, 3'd1, 2'b11, 8'h03, 1'b1, 2, "rol4");

        // Start held high while busy: only the first request counts.
        a = 8'h0F; amt = 3'd3; mode = 2'b00; start1 = 1'b1;
        tick();
        a = 8'hFF; amt = 3'd1; mode = 2'b11;
        cyc = 1;
        while (!done1 && cyc < 40) begin
            tick();
            cyc++;
        end
        start1 = 1'b0;
        check("hold latency", cyc, 4);
        check("hold result", result1, 8'h78);
        check("hold carry", carry1, 0);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done1) ndone++;
        end
        check("hold extra done", ndone, 0);
        check("hold idle", busy1, 0);
        $display("op hold: result=%02h carry=%0b lat=%0d extra_done=%0d", result1, carry1, cyc, ndone);

        // Reset in the middle of a shift aborts it without a done pulse.
        a = 8'hFF; amt = 3'd7; mode = 2'b00; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort result", result1, 0);
        check("abort carry", carry1, 0);
        check("abort busy", busy1, 0);
        check("abort done", done1, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done1) ndone++;
        end
        check("abort no done", ndone, 0);
        $display("op abort: busy=%0b extra_done=%0d", busy1, ndone);
        run_op(1'b0, 8'hFF, 3'd7, 2'b00, 8'h80, 1'b1, 8, "after_abort");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
